// File: rtl/motoro3_ramp_controller.sv
// Step-period ramp sequencer for the motor step generator: IDLE -> ALIGN -> ACCEL <-> RUN -> DECEL -> IDLE.
// Optional stall watchdog with FAULT state when M3_STALL_WDOG_EN is defined; otherwise fault is tied low.
module motoro3_ramp_controller #(
  parameter logic [24:0] P_START_PERIOD = 25'd1_666_667,
  parameter logic [24:0] P_MIN_PERIOD   = 25'd1_667,
  parameter logic [24:0] P_RAMP_DELTA   = 25'd16_384
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        cmdRun,
  input  logic [24:0] cmdTarget,
  input  logic        stepTick,
  output logic        m3start,
  output logic [24:0] m3period,
  output logic        atSpeed,
  output logic        fault,
  output logic [2:0]  state
);

  // No handshake: cmdRun/cmdTarget are levels sampled every falling edge, stepTick is a
  // one-clock strobe with no back-pressure, and all outputs are registered on the falling edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ACCEL = 3'd2,
    S_RUN   = 3'd3,
    S_DECEL = 3'd4,
    S_FAULT = 3'd7
  } state_t;

  state_t      state_q, state_n;
  logic [24:0] period_q, period_n;
  logic [2:0]  align_q, align_n;
  logic [24:0] tgt;
  logic [25:0] dec_sum;
  logic [25:0] inc_sum;
  logic [24:0] toward_tgt;
  logic [24:0] toward_start;
  logic        wdog_trip;

  assign state    = state_q;
  assign m3period = period_q;

  assign tgt = (cmdTarget < P_MIN_PERIOD) ? P_MIN_PERIOD : cmdTarget;

  // One extra bit catches borrow/carry so a ramp step clamps instead of wrapping.
  assign dec_sum = {1'b0, period_q} - {1'b0, P_RAMP_DELTA};
  assign inc_sum = {1'b0, period_q} + {1'b0, P_RAMP_DELTA};

  always_comb begin
    toward_tgt = period_q;
    if (period_q > tgt) begin
      if (dec_sum[25] || (dec_sum[24:0] < tgt)) toward_tgt = tgt;
      else                                       toward_tgt = dec_sum[24:0];
    end else if (period_q < tgt) begin
      if (inc_sum[25] || (inc_sum[24:0] > tgt)) toward_tgt = tgt;
      else                                       toward_tgt = inc_sum[24:0];
    end
  end

  always_comb begin
    if (inc_sum[25] || (inc_sum[24:0] > {1'b0, P_START_PERIOD}))
      toward_start = P_START_PERIOD;
    else
      toward_start = inc_sum[24:0];
  end

`ifdef M3_STALL_WDOG_EN
  logic [25:0] wdog_q;
  logic [25:0] wdog_inc;

  assign wdog_inc = wdog_q + 26'd1;
  // Trip on the clock whose count would exceed twice the current period.
  assign wdog_trip = m3start && !stepTick && (wdog_inc > {period_q, 1'b0});

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst)                    wdog_q <= '0;
    else if (!m3start || stepTick) wdog_q <= '0;
    else                           wdog_q <= wdog_inc;
  end
`else
  assign wdog_trip = 1'b0;
`endif

  // A state change always wins over a coincident stepTick; the period then holds.
  always_comb begin
    state_n  = state_q;
    period_n = period_q;
    align_n  = align_q;
    case (state_q)
      S_IDLE: begin
        period_n = P_START_PERIOD;
        if (cmdRun) begin
          state_n = S_ALIGN;
          align_n = '0;
        end
      end
      S_ALIGN: begin
        period_n = P_START_PERIOD;
        if (wdog_trip)     state_n = S_FAULT;
        else if (!cmdRun)  state_n = S_DECEL;
        else if (stepTick) begin
          align_n = align_q + 3'd1;
          if (align_q == 3'd5) state_n = S_ACCEL;
        end
      end
      S_ACCEL: begin
        if (wdog_trip)             state_n  = S_FAULT;
        else if (!cmdRun)          state_n  = S_DECEL;
        else if (period_q == tgt)  state_n  = S_RUN;
        else if (stepTick)         period_n = toward_tgt;
      end
      S_RUN: begin
        if (wdog_trip)            state_n = S_FAULT;
        else if (!cmdRun)         state_n = S_DECEL;
        else if (tgt != period_q) state_n = S_ACCEL;
      end
      S_DECEL: begin
        if (wdog_trip)    state_n = S_FAULT;
        else if (cmdRun)  state_n = S_ACCEL;
        else if (stepTick) begin
          if (period_q == P_START_PERIOD) begin
            state_n  = S_IDLE;
            period_n = P_START_PERIOD;
          end else begin
            period_n = toward_start;
          end
        end
      end
      S_FAULT: begin
        if (!cmdRun) begin
          state_n  = S_IDLE;
          period_n = P_START_PERIOD;
        end
      end
      default: begin
        state_n  = S_IDLE;
        period_n = P_START_PERIOD;
      end
    endcase
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      period_q <= P_START_PERIOD;
      align_q  <= '0;
      m3start  <= 1'b0;
      atSpeed  <= 1'b0;
`ifdef M3_STALL_WDOG_EN
      fault    <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      period_q <= period_n;
      align_q  <= align_n;
      m3start  <= (state_n == S_ALIGN) || (state_n == S_ACCEL) ||
                  (state_n == S_RUN)   || (state_n == S_DECEL);
      atSpeed  <= (state_n == S_RUN);
`ifdef M3_STALL_WDOG_EN
      fault    <= (state_n == S_FAULT);
`endif
    end
  end

`ifndef M3_STALL_WDOG_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_motoro3_ramp_controller.sv
// Bench for motoro3_ramp_controller: directed ramp scenarios plus random stimulus, every clock
// compared against an arithmetic model of the ramp rules.
`timescale 1ns/1ps
module tb_motoro3_ramp_controller;

  localparam logic [24:0] START = 25'd1_666_667;
  localparam logic [24:0] MINP  = 25'd1_667;
  localparam logic [24:0] DELTA = 25'd16_384;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        cmdRun = 1'b0;
  logic [24:0] cmdTarget = '0;
  logic        stepTick = 1'b0;
  logic        m3start;
  logic [24:0] m3period;
  logic        atSpeed;
  logic        fault;
  logic [2:0]  state;

  motoro3_ramp_controller dut (
    .clk(clk), .nRst(nRst), .cmdRun(cmdRun), .cmdTarget(cmdTarget), .stepTick(stepTick),
    .m3start(m3start), .m3period(m3period), .atSpeed(atSpeed), .fault(fault), .state(state)
  );

  // 10 MHz clock; the DUT acts on the falling edge, the bench samples on the rising edge
  always #50 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: states by their numeric codes, periods as unbounded integers
  int     m_state;
  longint m_period;
  int     m_align;
  longint m_wd;

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction
  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction
  function automatic bit m_active(input int s);
    return (s == 1) || (s == 2) || (s == 3) || (s == 4);
  endfunction

  task automatic model_reset();
    m_state = 0; m_period = START; m_align = 0; m_wd = 0;
  endtask

  task automatic model_clock();
    longint tg;
    longint np;
    int     ns;
    bit     stall;
    tg = lmax(longint'(cmdTarget), longint'(MINP));
    ns = m_state;
    np = m_period;
    stall = 1'b0;
`ifdef M3_STALL_WDOG_EN
    stall = m_active(m_state) && !stepTick && (m_wd + 1 > 2 * m_period);
    if (!m_active(m_state) || stepTick) m_wd = 0;
    else m_wd = m_wd + 1;
`endif
    case (m_state)
      0: if (cmdRun) begin ns = 1; m_align = 0; end
      1: if (stall) ns = 7;
         else if (!cmdRun) ns = 4;
         else if (stepTick) begin
           m_align++;
           if (m_align == 6) ns = 2;
         end
      2: if (stall) ns = 7;
         else if (!cmdRun) ns = 4;
         else if (m_period == tg) ns = 3;
         else if (stepTick)
           np = (m_period > tg) ? lmax(m_period - DELTA, tg) : lmin(m_period + DELTA, tg);
      3: if (stall) ns = 7;
         else if (!cmdRun) ns = 4;
         else if (m_period != tg) ns = 2;
      4: if (stall) ns = 7;
         else if (cmdRun) ns = 2;
         else if (stepTick) begin
           if (m_period == START) ns = 0;
           else np = lmin(m_period + DELTA, START);
         end
      7: if (!cmdRun) ns = 0;
      default: ns = 0;
    endcase
    if (ns == 0 || ns == 1) np = START;
    m_state = ns;
    m_period = np;
  endtask

  task automatic compare_all();
    check("state",    32'(state),    32'(m_state));
    check("m3period", 32'(m3period), 32'(m_period));
    check("m3start",  32'(m3start),  32'(m_active(m_state)));
    check("atSpeed",  32'(atSpeed),  32'(m_state == 3));
    check("fault",    32'(fault),    32'(m_state == 7));
  endtask

  // Drive one clock's inputs, let the DUT and model step at the falling edge, check at the rising edge
  task automatic cycle(input bit run, input logic [24:0] tg, input bit tick);
    cmdRun = run; cmdTarget = tg; stepTick = tick;
    @(negedge clk);
    model_clock();
    @(posedge clk);
    compare_all();
  endtask

  task automatic run_until(input int want, input bit run, input logic [24:0] tg,
                           input int every, input int limit, input string tag);
    int n;
    n = 0;
    while (state !== 3'(want) && n < limit) begin
      cycle(run, tg, (n % every) == (every - 1));
      n++;
    end
    check(tag, 32'(state), 32'(want));
  endtask

  initial begin
    #20ms;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    check("rst_state",   32'(state),    32'(0));
    check("rst_m3start", 32'(m3start),  32'(0));
    check("rst_period",  32'(m3period), 32'(START));
    check("rst_fault",   32'(fault),    32'(0));
    check("rst_atSpeed", 32'(atSpeed),  32'(0));
    nRst = 1'b1;
    repeat (3) cycle(0, 25'd1_600_000, 0);

    // Align for six ticks, then ramp down to 1_600_000
    exp_q = {25'd1_650_283, 25'd1_633_899, 25'd1_617_515, 25'd1_601_131, 25'd1_600_000};
    for (int t = 0; t < 11; t++) begin
      for (int c = 0; c < 99; c++) cycle(1, 25'd1_600_000, 0);
      cycle(1, 25'd1_600_000, 1);
      if (t == 4) check("align_after_5", 32'(state), 32'(1));
      if (t == 5) check("accel_after_6", 32'(state), 32'(2));
      if (t >= 6) check("accel_period", 32'(m3period), 32'(exp_q.pop_front()));
    end
    cycle(1, 25'd1_600_000, 0);
    check("run_state",   32'(state),   32'(3));
    check("run_atSpeed", 32'(atSpeed), 32'(1));

    // Stop: ramp back up to the start period, then IDLE on the following tick
    cycle(0, 25'd1_600_000, 0);
    check("decel_state", 32'(state), 32'(4));
    exp_q = {25'd1_616_384, 25'd1_632_768, 25'd1_649_152, 25'd1_665_536, 25'd1_666_667};
    for (int t = 0; t < 5; t++) begin
      repeat (9) cycle(0, 25'd1_600_000, 0);
      cycle(0, 25'd1_600_000, 1);
      check("decel_period", 32'(m3period), 32'(exp_q.pop_front()));
    end
    repeat (9) cycle(0, 25'd1_600_000, 0);
    cycle(0, 25'd1_600_000, 1);
    check("decel_idle",    32'(state),   32'(0));
    check("decel_m3start", 32'(m3start), 32'(0));

    // Target below the minimum clamps to the minimum period
    run_until(3, 1, 25'd5, 4, 3000, "reach_run_min");
    check("min_period", 32'(m3period), 32'(MINP));
    for (int i = 0; i < 20; i++) cycle(1, 25'd5, (i % 2) == 1);
    check("hold_min_state",  32'(state),    32'(3));
    check("hold_min_period", 32'(m3period), 32'(MINP));
    cycle(0, 25'd5, 1);
    check("stop_tick_state",  32'(state),    32'(4));
    check("stop_tick_period", 32'(m3period), 32'(MINP));
    cycle(0, 25'd5, 0);
    cycle(0, 25'd5, 1);
    check("first_decel_step", 32'(m3period), 32'(MINP + DELTA));
    run_until(0, 0, 25'd5, 3, 1000, "back_to_idle");

    // Stall in RUN at the minimum period
    run_until(3, 1, 25'd5, 4, 3000, "stall_reach_run");
    cycle(1, 25'd5, 1);
`ifdef M3_STALL_WDOG_EN
    n = 0;
    while (state !== 3'd7 && n < 5000) begin
      cycle(1, 25'd5, 0);
      n++;
    end
    check("wdog_clocks",   32'(n),       32'(3335));
    check("wdog_fault",    32'(fault),   32'(1));
    check("wdog_m3start",  32'(m3start), 32'(0));
    cycle(1, 25'd5, 0);
    check("fault_holds",   32'(state),   32'(7));
    cycle(0, 25'd5, 0);
    check("fault_to_idle", 32'(state),   32'(0));
`else
    n = 0;
    repeat (5000) cycle(1, 25'd5, 0);
    check("no_wdog_state", 32'(state), 32'(3));
    check("no_wdog_fault", 32'(fault), 32'(0));
    run_until(0, 0, 25'd5, 3, 1000, "pre_rst_idle");
`endif

    // Asynchronous reset in the middle of a ramp
    run_until(2, 1, 25'd100_000, 4, 200, "reach_accel");
    repeat (12) cycle(1, 25'd100_000, 0);
    check("mid_accel", 32'(state), 32'(2));
    #20;
    nRst = 1'b0;
    #1;
    check("arst_state",   32'(state),    32'(0));
    check("arst_m3start", 32'(m3start),  32'(0));
    check("arst_period",  32'(m3period), 32'(START));
    check("arst_atSpeed", 32'(atSpeed),  32'(0));
    check("arst_fault",   32'(fault),    32'(0));
    model_reset();
    cmdRun = 1'b0; stepTick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    nRst = 1'b1;

    // Random commands, targets and ticks
    begin
      bit          run;
      logic [24:0] tg;
      run = 1'b1;
      tg = 25'd200_000;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 199) == 0) run = ~run;
        if ($urandom_range(0, 149) == 0) begin
          case ($urandom_range(0, 3))
            0: tg = 25'($urandom_range(0, 1666));
            1: tg = 25'($urandom_range(1667, 300_000));
            2: tg = 25'($urandom_range(300_000, 1_666_667));
            default: tg = 25'($urandom_range(1_666_668, 33_554_431));
          endcase
        end
        cycle(run, tg, $urandom_range(0, 2) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
